mulalu: RTL and testbench
=========================

Name: mulalu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the single-cycle ALU.
- Consumes the ALU's mulalu_func / mulalu_sign qualifiers and both EX operands.
- Stalls the pipeline while busy, then writes the 64-bit result into HI/LO via one-cycle write strobes.
- Iterative radix-2 restoring divider; two-cycle magnitude multiplier.

Parameters:
- DATA_W, 32, operand and HI/LO width; the design is verified only at 32.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- flush  in  1  exception/flush from commit; aborts any operation in flight
- func  in  5  `FUNC_MUL, `FUNC_DIV, or 5'b00000 (idle)
- sign  in  1  1 = signed operation (MULT/DIV), 0 = unsigned (MULTU/DIVU)
- source_a  in  DATA_W  multiplicand / dividend
- source_b  in  DATA_W  multiplier / divisor
- stall  out  1  hold EX and all earlier stages
- hi_write  out  1  HI write strobe
- hi_write_data  out  DATA_W  product[63:32] / remainder
- lo_write  out  1  LO write strobe
- lo_write_data  out  DATA_W  product[31:0] / quotient

Behaviour:
- Clocking and reset:
  - All state is updated on the clk rising edge.
  - rst = 1 forces state IDLE, clears counters and operand registers, and drives hi_write = lo_write = 0 and both write_data buses to 0.
- States: IDLE, MUL, DIV, DONE.
- start = (state == IDLE) & ~flush & (func == `FUNC_MUL | func == `FUNC_DIV).
- stall = start | (state == MUL) | (state == DIV). It is combinational and low in IDLE (without start) and in DONE.
- IDLE, on start:
  - Latch |a| and |b|. Magnitudes are taken only when sign = 1; otherwise operands are latched raw.
  - Latch neg_q = sign & (a[31] ^ b[31]) and neg_r = sign & a[31].
  - Next state is MUL or DIV according to func.
- MUL:
  - One cycle: register the 64-bit unsigned product of the magnitudes.
  - Then go to DONE.
  - Latency: start at cycle T, DONE at T+2; stall is high for T..T+1.
- DIV:
  - 32 iterations, one quotient bit per cycle, counter 0..31 MSB-first, restoring shift/subtract on a 33-bit partial remainder.
  - After count 31, go to DONE.
  - Latency: start at T, DONE at T+33; stall is high for T..T+32.
- DONE:
  - hi_write = lo_write = 1 for exactly one cycle.
  - Data is sign-fixed:
    - MUL: the product is negated (two's complement, 64-bit) if neg_q.
    - DIV: the quotient is negated if neg_q; the remainder is negated if neg_r.
  - Next state is IDLE unconditionally. func is ignored in DONE, so the still-present instruction does not restart.
  - A new mul/div in the following cycle starts normally from IDLE.
- Outside DONE, hi_write = lo_write = 0. Write data buses are don't-care when the strobes are low, but the implementation holds the last value.
- Divide by zero:
  - No trap.
  - Unsigned: quotient = 0xFFFFFFFF, remainder = dividend. This is the natural outcome of the restoring algorithm.
  - Signed: the same magnitude result followed by the normal sign fixup.
  - Latency is unchanged (33).
- Overflow case 0x80000000 / 0xFFFFFFFF (signed):
  - Quotient = 0x80000000, remainder = 0.
  - This is the natural wrap; no exception.
- flush:
  - Synchronous, with priority over start and DONE.
  - In any state, the next state is IDLE and no write strobe is issued.
  - If flush coincides with DONE, hi_write and lo_write are suppressed that cycle.
  - stall drops to 0 in the flush cycle.
- rst mid-operation: same as flush, and additionally clears registers.
- Simultaneous func change while busy: ignored; operands were latched at start.

Decomposition:
- Shared defines header (already holds `W_DATA, `W_FUNC, `FUNC_MUL, `FUNC_DIV) gains:
  - state encoding `MDU_IDLE/MUL/DIV/DONE (2 bits);
  - `DIV_ITER = 32.
- One sub-module, mulalu_div: the unsigned 32-iteration restoring divider.
  - Ports: clk, rst, kill, start, dividend, divisor, busy, quotient, remainder.
  - The parent handles sign conversion, the multiplier and the FSM.

Test Plan:
- Unsigned MUL: a = 0xFFFFFFFF, b = 0x00000002, sign = 0 -> stall high 2 cycles; at T+2 hi_write = lo_write = 1, HI = 0x00000001, LO = 0xFFFFFFFE.
- Signed MUL: a = 0xFFFFFFFD (-3), b = 0x00000005, sign = 1 -> at T+2, HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; stall returns to 0 at T+2.
- Signed DIV: a = 0xFFFFFFF9 (-7), b = 0x00000002 -> stall is high for exactly 33 cycles; at T+33, LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1).
- Divide by zero and signed overflow:
  - DIVU 0x00001234 / 0 -> LO = 0xFFFFFFFF, HI = 0x00001234.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0x00000000.
- flush mid-DIV at T+10 -> stall is 0 that cycle, state is IDLE, no hi_write/lo_write at T+33. A MULTU 3 × 4 started at T+12 yields LO = 12, HI = 0 at T+14.
- Back-to-back:
  - MULTU held during stall, then DIVU 100 / 7 issued the cycle after DONE -> exactly one write per operation.
  - Second result: LO = 14, HI = 2.
  - rst asserted mid-MUL -> no write, all outputs 0.

Source files
------------

// File: rtl/mulalu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package mulalu_pkg;

  localparam int W_DATA   = 32;
  localparam int W_FUNC   = 5;
  localparam int DIV_ITER = 32;

  localparam logic [W_FUNC-1:0] FUNC_IDLE = 5'b00000;
  localparam logic [W_FUNC-1:0] FUNC_MUL  = 5'b11000;
  localparam logic [W_FUNC-1:0] FUNC_DIV  = 5'b11010;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mulalu_div.sv
// Unsigned radix-2 restoring divider. The first quotient bit is resolved
// on the start edge, so 32 bits are ready DIV_ITER cycles after start and
// busy is already low in the last DIV-state cycle of the parent.
module mulalu_div
  import mulalu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] rem, quo, dsr;
  logic [4:0]        cnt;
  logic              running;

  logic [DATA_W-1:0] src_rem, src_quo, src_dsr;
  logic [DATA_W:0]   shifted;
  logic              ge;
  logic [DATA_W-1:0] nrem, nquo;

  // One restoring step; on start it works on the fresh operands.
  always_comb begin
    src_rem = start ? '0 : rem;
    src_quo = start ? dividend : quo;
    src_dsr = start ? divisor : dsr;
    shifted = {src_rem, src_quo[DATA_W-1]};
    ge      = shifted >= {1'b0, src_dsr};
    // Result of the subtraction is below the divisor, so it fits DATA_W bits.
    nrem    = ge ? (shifted[DATA_W-1:0] - src_dsr) : shifted[DATA_W-1:0];
    nquo    = {src_quo[DATA_W-2:0], ge};
  end

  // Iteration register: quotient bits shift in behind the dividend.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= '0;
      quo     <= '0;
      dsr     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (kill) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= nrem;
      quo     <= nquo;
      dsr     <= divisor;
      cnt     <= 5'd1;
      running <= 1'b1;
    end else if (running) begin
      rem <= nrem;
      quo <= nquo;
      cnt <= cnt + 5'd1;
      if (cnt == 5'(DIV_ITER - 1)) running <= 1'b0;
    end
  end

  assign busy      = running;
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/mulalu.sv
// EX-stage multiply/divide unit: stalls the pipe while busy, then writes
// the sign-fixed 64-bit result into HI/LO with one-cycle strobes.
module mulalu
  import mulalu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [W_FUNC-1:0] func,
  input  logic              sign,
  input  logic [DATA_W-1:0] source_a,
  input  logic [DATA_W-1:0] source_b,
  output logic              stall,
  output logic              hi_write,
  output logic [DATA_W-1:0] hi_write_data,
  output logic              lo_write,
  output logic [DATA_W-1:0] lo_write_data
);

  localparam int PW = 2 * DATA_W;

  mdu_state_e state, state_nxt;

  logic              start, is_mul, is_div_op;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic              neg_q, neg_r, is_div;
  logic [PW-1:0]     prod, prod_fix;
  logic [DATA_W-1:0] fix_hi, fix_lo;
  logic [DATA_W-1:0] hold_hi, hold_lo;
  logic              div_busy;
  logic [DATA_W-1:0] div_q, div_r;

  assign is_mul    = (func == FUNC_MUL);
  assign is_div_op = (func == FUNC_DIV);
  assign start     = (state == MDU_IDLE) & ~flush & (is_mul | is_div_op);

  // Operand magnitudes; unsigned ops pass operands through untouched.
  always_comb begin
    mag_a = (sign & source_a[DATA_W-1]) ? -source_a : source_a;
    mag_b = (sign & source_b[DATA_W-1]) ? -source_b : source_b;
  end

  mulalu_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .kill      (flush),
    .start     (start & is_div_op),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .busy      (div_busy),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nxt;
  end

  // Next state; flush wins over start and DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (start) state_nxt = is_div_op ? MDU_DIV : MDU_MUL;
      MDU_MUL:  state_nxt = MDU_DONE;
      MDU_DIV:  if (!div_busy) state_nxt = MDU_DONE;
      MDU_DONE: state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
    if (flush) state_nxt = MDU_IDLE;
  end

  // Operand latch, magnitude product, and last-written result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_mag   <= '0;
      b_mag   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      is_div  <= 1'b0;
      prod    <= '0;
      hold_hi <= '0;
      hold_lo <= '0;
    end else begin
      if (start) begin
        a_mag  <= mag_a;
        b_mag  <= mag_b;
        neg_q  <= sign & (source_a[DATA_W-1] ^ source_b[DATA_W-1]);
        neg_r  <= sign & source_a[DATA_W-1];
        is_div <= is_div_op;
      end
      if (state == MDU_MUL)
        prod <= {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
      if (state == MDU_DONE && !flush) begin
        hold_hi <= fix_hi;
        hold_lo <= fix_lo;
      end
    end
  end

  // Sign fixup of the finished magnitude result.
  always_comb begin
    prod_fix = neg_q ? -prod : prod;
    if (is_div) begin
      fix_hi = neg_r ? -div_r : div_r;
      fix_lo = neg_q ? -div_q : div_q;
    end else begin
      fix_hi = prod_fix[PW-1:DATA_W];
      fix_lo = prod_fix[DATA_W-1:0];
    end
  end

  // Outputs: stall while working, strobes only in an unflushed DONE.
  always_comb begin
    stall         = ~flush & (start | (state == MDU_MUL) | (state == MDU_DIV));
    hi_write      = (state == MDU_DONE) & ~flush & ~rst;
    lo_write      = hi_write;
    hi_write_data = hold_hi;
    lo_write_data = hold_lo;
    if ((state == MDU_DONE) && !rst) begin
      hi_write_data = fix_hi;
      lo_write_data = fix_lo;
    end
  end

endmodule

// File: tb/tb_mulalu.sv
// Directed bench for mulalu: latency, sign fixup, corner cases, flush/reset.
module tb_mulalu;
  import mulalu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, sign;
  logic [4:0]  func;
  logic [31:0] source_a, source_b;
  logic        stall, hi_write, lo_write;
  logic [31:0] hi_write_data, lo_write_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  mulalu #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .func          (func),
    .sign          (sign),
    .source_a      (source_a),
    .source_b      (source_b),
    .stall         (stall),
    .hi_write      (hi_write),
    .hi_write_data (hi_write_data),
    .lo_write      (lo_write),
    .lo_write_data (lo_write_data)
  );

  // Count every write strobe the unit issues.
  always @(negedge clk) if (hi_write === 1'b1) wr_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] f, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    func = f; sign = s; source_a = a; source_b = b;
    #1;
  endtask

  task automatic idle();
    func = FUNC_IDLE; sign = 1'b0;
    #1;
  endtask

  // Counts stall cycles until stall drops (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (stall === 1'b1 && lat < 100) begin
      lat++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    issue(FUNC_IDLE, 1'b0, 32'h0, 32'h0);
    step(); step();
    rst = 1'b0;
    #1;
    chk_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else pass_cnt++;
    chk_cnt++; if ({hi_write, lo_write} !== 2'b00) $display("FAIL reset_wr got %b want 00", {hi_write, lo_write}); else pass_cnt++;
    chk_cnt++; if ({hi_write_data, lo_write_data} !== 64'h0) $display("FAIL reset_data got %h want 0", {hi_write_data, lo_write_data}); else pass_cnt++;
    step();
  endtask

  task automatic test_mul_unsigned();
    int lat;
    issue(FUNC_MUL, 1'b0, 32'hFFFFFFFF, 32'h00000002);
    chk_cnt++; if (stall !== 1'b1) $display("FAIL mulu_start_stall got %b want 1", stall); else pass_cnt++;
    wait_done(lat);
    chk_cnt++; if (lat != 2) $display("FAIL mulu_latency got %0d want 2", lat); else pass_cnt++;
    chk_cnt++; if ({hi_write, lo_write} !== 2'b11) $display("FAIL mulu_strobe got %b want 11", {hi_write, lo_write}); else pass_cnt++;
    chk_cnt++; if ({hi_write_data, lo_write_data} !== 64'h00000001_FFFFFFFE) $display("FAIL mulu_data got %h want 00000001fffffffe", {hi_write_data, lo_write_data}); else pass_cnt++;
    step(); idle();
    chk_cnt++; if (hi_write !== 1'b0 || stall !== 1'b0) $display("FAIL mulu_after got wr=%b st=%b want 0 0", hi_write, stall); else pass_cnt++;
    chk_cnt++; if (lo_write_data !== 32'hFFFFFFFE) $display("FAIL mulu_hold got %h want fffffffe", lo_write_data); else pass_cnt++;
  endtask

  task automatic test_mul_signed();
    int lat;
    issue(FUNC_MUL, 1'b1, 32'hFFFFFFFD, 32'h00000005);
    wait_done(lat);
    chk_cnt++; if (lat != 2) $display("FAIL muls_latency got %0d want 2", lat); else pass_cnt++;
    chk_cnt++; if ({hi_write_data, lo_write_data} !== 64'hFFFFFFFF_FFFFFFF1) $display("FAIL muls_data got %h want fffffffffffffff1", {hi_write_data, lo_write_data}); else pass_cnt++;
    step(); idle();
  endtask

  task automatic test_div_signed();
    int lat;
    issue(FUNC_DIV, 1'b1, 32'hFFFFFFF9, 32'h00000002);
    wait_done(lat);
    chk_cnt++; if (lat != 33) $display("FAIL divs_latency got %0d want 33", lat); else pass_cnt++;
    chk_cnt++; if ({hi_write, lo_write} !== 2'b11) $display("FAIL divs_strobe got %b want 11", {hi_write, lo_write}); else pass_cnt++;
    chk_cnt++; if ({hi_write_data, lo_write_data} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL divs_data got %h want fffffffffffffffd", {hi_write_data, lo_write_data}); else pass_cnt++;
    step(); idle();
  endtask

  task automatic test_div_corners();
    int lat;
    issue(FUNC_DIV, 1'b0, 32'h00001234, 32'h00000000);
    wait_done(lat);
    chk_cnt++; if (lat != 33) $display("FAIL divz_latency got %0d want 33", lat); else pass_cnt++;
    chk_cnt++; if ({hi_write_data, lo_write_data} !== 64'h00001234_FFFFFFFF) $display("FAIL divz_data got %h want 00001234ffffffff", {hi_write_data, lo_write_data}); else pass_cnt++;
    step(); idle(); step();
    issue(FUNC_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    chk_cnt++; if ({hi_write_data, lo_write_data} !== 64'h00000000_80000000) $display("FAIL divovf_data got %h want 0000000080000000", {hi_write_data, lo_write_data}); else pass_cnt++;
    step(); idle();
  endtask

  task automatic test_flush();
    int lat, w0;
    w0 = wr_cnt;
    issue(FUNC_DIV, 1'b0, 32'd1000, 32'd3);
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1; #1;
    chk_cnt++; if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else pass_cnt++;
    step();
    flush = 1'b0; idle();
    chk_cnt++; if (stall !== 1'b0) $display("FAIL flush_idle_stall got %b want 0", stall); else pass_cnt++;
    step();
    issue(FUNC_MUL, 1'b0, 32'd3, 32'd4);
    wait_done(lat);
    chk_cnt++; if (lat != 2) $display("FAIL flush_mul_latency got %0d want 2", lat); else pass_cnt++;
    chk_cnt++; if ({hi_write_data, lo_write_data} !== 64'd12) $display("FAIL flush_mul_data got %h want 12", {hi_write_data, lo_write_data}); else pass_cnt++;
    step(); idle();
    for (int i = 0; i < 30; i++) step();
    chk_cnt++; if (wr_cnt - w0 != 1) $display("FAIL flush_writes got %0d want 1", wr_cnt - w0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, w0;
    w0 = wr_cnt;
    issue(FUNC_MUL, 1'b0, 32'd5, 32'd6);
    wait_done(lat);
    chk_cnt++; if ({hi_write, lo_write_data} !== {1'b1, 32'd30}) $display("FAIL b2b_mul got wr=%b lo=%h want 1 1e", hi_write, lo_write_data); else pass_cnt++;
    step();
    issue(FUNC_DIV, 1'b0, 32'd100, 32'd7);
    chk_cnt++; if (stall !== 1'b1) $display("FAIL b2b_div_start got %b want 1", stall); else pass_cnt++;
    wait_done(lat);
    chk_cnt++; if (lat != 33) $display("FAIL b2b_div_latency got %0d want 33", lat); else pass_cnt++;
    chk_cnt++; if ({hi_write_data, lo_write_data} !== {32'd2, 32'd14}) $display("FAIL b2b_div_data got %h want 000000020000000e", {hi_write_data, lo_write_data}); else pass_cnt++;
    step(); idle(); step();
    chk_cnt++; if (wr_cnt - w0 != 2) $display("FAIL b2b_writes got %0d want 2", wr_cnt - w0); else pass_cnt++;
  endtask

  task automatic test_rst_mid_mul();
    int w0;
    w0 = wr_cnt;
    issue(FUNC_MUL, 1'b0, 32'd7, 32'd9);
    step();
    rst = 1'b1; idle();
    step();
    rst = 1'b0; #1;
    chk_cnt++; if ({stall, hi_write, lo_write} !== 3'b000) $display("FAIL rst_mul_ctl got %b want 000", {stall, hi_write, lo_write}); else pass_cnt++;
    chk_cnt++; if ({hi_write_data, lo_write_data} !== 64'h0) $display("FAIL rst_mul_data got %h want 0", {hi_write_data, lo_write_data}); else pass_cnt++;
    for (int i = 0; i < 4; i++) step();
    chk_cnt++; if (wr_cnt - w0 != 0) $display("FAIL rst_mul_writes got %0d want 0", wr_cnt - w0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mul_unsigned();
    test_mul_signed();
    test_div_signed();
    test_div_corners();
    test_flush();
    test_back_to_back();
    test_rst_mid_mul();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
